// File: rtl/flit_deaggregator.sv
// flit_deaggregator: unpacks a wide word of NOC_SPEEDUP flit slots into a registered one-flit-per-cycle stream.
// Define FLIT_DEAGG_PROTOCOL_CHECK_EN to enable the sticky head/tail framing checker on o_proto_err.
module flit_deaggregator #(
    parameter int DATA_WIDTH       = 128,
    parameter int ADDRESS_WIDTH    = 4,
    parameter int VC_ADDRESS_WIDTH = 1,
    parameter int NOC_SPEEDUP      = 4
) (
    input  logic                                                                clk,
    input  logic                                                                rst,
    input  logic [NOC_SPEEDUP*(DATA_WIDTH+ADDRESS_WIDTH+VC_ADDRESS_WIDTH+3)-1:0] i_data_in,
    input  logic                                                                i_valid_in,
    output logic                                                                o_ready_in,
    output logic [DATA_WIDTH-1:0]                                               o_data_out,
    output logic [ADDRESS_WIDTH-1:0]                                            o_dest_out,
    output logic [ADDRESS_WIDTH-1:0]                                            o_extra_out,
    output logic [VC_ADDRESS_WIDTH-1:0]                                         o_vc_out,
    output logic                                                                o_head_out,
    output logic                                                                o_tail_out,
    output logic                                                                o_valid_out,
    input  logic                                                                i_ready_out,
    output logic                                                                o_proto_err
);

    localparam int FW = DATA_WIDTH + ADDRESS_WIDTH + VC_ADDRESS_WIDTH + 3;
    // The valid bit lives in the pending mask, so stored slots drop it.
    localparam int SW = FW - 1;
    localparam int IW = $clog2(NOC_SPEEDUP);
    localparam int LW = DATA_WIDTH + ADDRESS_WIDTH;
    localparam logic [NOC_SPEEDUP-1:0] MASK_ONE = NOC_SPEEDUP'(1);

    typedef enum logic {EMPTY, DRAIN} state_t;

    state_t                 state;
    logic [NOC_SPEEDUP-1:0] mask;
    logic [NOC_SPEEDUP-1:0] new_mask;
    logic [NOC_SPEEDUP-1:0] rem_mask;
    logic [NOC_SPEEDUP-1:0] src_mask;
    logic [SW-1:0]          hold_slots [NOC_SPEEDUP];
    logic [SW-1:0]          new_slots  [NOC_SPEEDUP];
    logic [IW-1:0]          cur_idx;
    logic [IW-1:0]          nxt_idx;
    logic [SW-1:0]          nxt_slot;
    logic                   handshake;
    logic                   accept;

    function automatic logic [IW-1:0] lowest_set(input logic [NOC_SPEEDUP-1:0] m);
        lowest_set = '0;
        for (int k = NOC_SPEEDUP - 1; k >= 0; k--) begin
            if (m[k]) lowest_set = IW'(k);
        end
    endfunction

    assign o_valid_out = (state == DRAIN);
    assign o_ready_in  = (state == EMPTY) ||
                         ((state == DRAIN) && i_ready_out && ((mask & (mask - MASK_ONE)) == '0));

    // Next presented slot comes from the incoming word when one is accepted, else from what remains held.
    always_comb begin
        for (int k = 0; k < NOC_SPEEDUP; k++) begin
            new_mask[k]  = i_data_in[k*FW + FW - 1];
            new_slots[k] = i_data_in[k*FW +: SW];
        end
        handshake = (state == DRAIN) && i_ready_out;
        accept    = i_valid_in && o_ready_in;
        rem_mask  = mask;
        if (handshake) rem_mask[cur_idx] = 1'b0;
        src_mask  = accept ? new_mask : rem_mask;
        nxt_idx   = lowest_set(src_mask);
        nxt_slot  = accept ? new_slots[nxt_idx] : hold_slots[nxt_idx];
    end

    always_ff @(posedge clk) begin
        if (accept) hold_slots <= new_slots;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= EMPTY;
            mask        <= '0;
            cur_idx     <= '0;
            o_data_out  <= '0;
            o_dest_out  <= '0;
            o_extra_out <= '0;
            o_vc_out    <= '0;
            o_head_out  <= 1'b0;
            o_tail_out  <= 1'b0;
        end else if (accept || handshake) begin
            mask    <= src_mask;
            cur_idx <= nxt_idx;
            if (src_mask == '0) begin
                state       <= EMPTY;
                o_data_out  <= '0;
                o_dest_out  <= '0;
                o_extra_out <= '0;
                o_vc_out    <= '0;
                o_head_out  <= 1'b0;
                o_tail_out  <= 1'b0;
            end else begin
                state      <= DRAIN;
                o_head_out <= nxt_slot[SW-1];
                o_tail_out <= nxt_slot[SW-2];
                o_vc_out   <= nxt_slot[LW +: VC_ADDRESS_WIDTH];
                if (nxt_slot[SW-1]) begin
                    o_dest_out  <= nxt_slot[DATA_WIDTH +: ADDRESS_WIDTH];
                    o_data_out  <= nxt_slot[DATA_WIDTH-1:0];
                    o_extra_out <= '0;
                end else begin
                    o_dest_out  <= '0;
                    o_data_out  <= nxt_slot[ADDRESS_WIDTH +: DATA_WIDTH];
                    o_extra_out <= nxt_slot[ADDRESS_WIDTH-1:0];
                end
            end
        end
    end

`ifdef FLIT_DEAGG_PROTOCOL_CHECK_EN
    logic pkt_open;

    // A head must open a packet and every other flit must land inside one.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_open    <= 1'b0;
            o_proto_err <= 1'b0;
        end else if (o_valid_out && i_ready_out) begin
            if (o_head_out == pkt_open) o_proto_err <= 1'b1;
            if (o_tail_out)             pkt_open    <= 1'b0;
            else if (o_head_out)        pkt_open    <= 1'b1;
        end
    end
`else
    assign o_proto_err = 1'b0;
`endif

endmodule
